// File: rtl/udp_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UDP TX byte stream.
// Holds the grant for a whole packet, then forces an inter-packet gap.
module udp_tx_arbiter #(
   parameter int NUM_SRC    = 2,
   parameter int GAP_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SRC-1:0]   src_valid,
   input  logic [8*NUM_SRC-1:0] src_data,
   input  logic [NUM_SRC-1:0]   src_last,
   output logic [NUM_SRC-1:0]   src_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_last,
   input  logic                 tx_ready,
   output logic [1:0]           grant_id,
   output logic                 dbg_busy,
   output logic [7:0]           dbg_data,
   output logic [15:0]          dbg_byte_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] XFER = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   logic [1:0] state;
   logic [3:0] gap_cnt;
   logic [1:0] pick;
   logic       found;
   logic       beat;

   // Rotating priority: distance 0 is the source right after the last grant.
   always_comb begin
      int d;
      int best_d;
      found  = 1'b0;
      pick   = grant_id;
      best_d = NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
         d = (i + NUM_SRC - 1 - int'(grant_id)) % NUM_SRC;
         if (src_valid[i] && d < best_d) begin
            best_d = d;
            pick   = 2'(i);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      tx_last   = 1'b0;
      src_ready = '0;
      if (state == XFER) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == 2'(i)) begin
               tx_valid     = src_valid[i];
               tx_data      = src_data[8*i +: 8];
               tx_last      = src_last[i];
               src_ready[i] = tx_ready;
            end
         end
      end
   end

   assign beat     = tx_valid & tx_ready;
   assign dbg_busy = (state == XFER);
   assign dbg_data = tx_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         grant_id     <= 2'(NUM_SRC - 1);
         dbg_byte_cnt <= 16'h0000;
         gap_cnt      <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id     <= pick;
                  dbg_byte_cnt <= 16'h0000;
                  state        <= XFER;
               end
            end
            XFER: begin
               if (beat) begin
                  if (dbg_byte_cnt != 16'hFFFF)
                     dbg_byte_cnt <= dbg_byte_cnt + 16'h0001;
                  if (tx_last) begin
                     state   <= GAP;
                     gap_cnt <= GAP_LOAD;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == 4'h0)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt - 4'h1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: directed vector table, corner sequences,
// and randomized traffic against a packet-level reference model.
module tb_udp_tx_arbiter;

   localparam int NUM_SRC    = 2;
   localparam int GAP_CYCLES = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NUM_SRC-1:0]   src_valid = '0;
   logic [8*NUM_SRC-1:0] src_data = '0;
   logic [NUM_SRC-1:0]   src_last = '0;
   logic [NUM_SRC-1:0]   src_ready;
   logic                 tx_valid;
   logic [7:0]           tx_data;
   logic                 tx_last;
   logic                 tx_ready = 1'b0;
   logic [1:0]           grant_id;
   logic                 dbg_busy;
   logic [7:0]           dbg_data;
   logic [15:0]          dbg_byte_cnt;

   always #5 clk = ~clk;

   udp_tx_arbiter #(
      .NUM_SRC   (NUM_SRC),
      .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_last    (src_last),
      .src_ready   (src_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_last     (tx_last),
      .tx_ready    (tx_ready),
      .grant_id    (grant_id),
      .dbg_busy    (dbg_busy),
      .dbg_data    (dbg_data),
      .dbg_byte_cnt(dbg_byte_cnt)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct {
      logic [1:0]  v;
      logic [7:0]  d0;
      logic        l0;
      logic        rdy;
      logic        tv;
      logic [7:0]  td;
      logic        tl;
      logic [1:0]  sr;
      logic [1:0]  gid;
      logic        busy;
      logic [15:0] cnt;
   } row_t;

   int vectors = 0;
   int miscompares = 0;

   beat_t q [NUM_SRC][$];

   // reference model state
   bit      mon_en = 1'b0;
   bit      m_busy, pend;
   int      m_last, m_g, m_cnt, pend_g, npkt, nacc;
   longint  cyc, free_at;
   int      grant_log[$];
   logic [NUM_SRC-1:0] acc = '0;

   int vpct = 100;
   int rpct = 100;
   bit toggle_rdy = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(int last, logic [NUM_SRC-1:0] v);
      for (int k = 1; k <= NUM_SRC; k++)
         if (v[(last + k) % NUM_SRC]) return (last + k) % NUM_SRC;
      return -1;
   endfunction

   function automatic bit q_pending();
      for (int i = 0; i < NUM_SRC; i++)
         if (q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_last  = NUM_SRC - 1;
      m_busy  = 1'b0;
      pend    = 1'b0;
      m_cnt   = 0;
      m_g     = 0;
      free_at = 0;
      cyc     = 0;
      npkt    = 0;
      nacc    = 0;
      grant_log.delete();
      for (int i = 0; i < NUM_SRC; i++) q[i].delete();
   endtask

   // Packet-level model: whole packets from queue heads, round-robin
   // choice at the first idle cycle with a request, fixed turnaround.
   always @(negedge clk) begin
      beat_t b;
      acc = src_valid & src_ready;
      if (mon_en && !rst) begin
         if (pend) begin
            chk("grant_busy", 32'(dbg_busy), 32'd1);
            chk("grant_id", 32'(grant_id), pend_g);
            m_busy = 1'b1;
            m_g    = pend_g;
            m_last = pend_g;
            m_cnt  = 0;
            pend   = 1'b0;
            grant_log.push_back(pend_g);
         end
         if (m_busy) begin
            chk("busy", 32'(dbg_busy), 32'd1);
            chk("xfer_grant", 32'(grant_id), m_g);
            chk("tx_valid", 32'(tx_valid), 32'(src_valid[m_g]));
            chk("src_ready", 32'(src_ready), 32'(tx_ready) << m_g);
            chk("byte_cnt", 32'(dbg_byte_cnt), m_cnt);
            if (src_valid[m_g]) begin
               if (q[m_g].size() == 0) begin
                  chk("q_underflow", 32'd1, 32'd0);
               end else begin
                  chk("tx_data", 32'(tx_data), 32'(q[m_g][0].d));
                  chk("dbg_data", 32'(dbg_data), 32'(q[m_g][0].d));
                  chk("tx_last", 32'(tx_last), 32'(q[m_g][0].l));
               end
            end
            if (src_valid[m_g] && tx_ready && q[m_g].size() != 0) begin
               b = q[m_g].pop_front();
               nacc++;
               if (m_cnt < 65535) m_cnt++;
               if (b.l) begin
                  m_busy  = 1'b0;
                  npkt++;
                  free_at = cyc + GAP_CYCLES + 1;
               end
            end
         end else begin
            chk("idle_valid", 32'(tx_valid), 32'd0);
            chk("idle_ready", 32'(src_ready), 32'd0);
            chk("idle_busy", 32'(dbg_busy), 32'd0);
            chk("idle_data", 32'(tx_data), 32'd0);
            chk("idle_last", 32'(tx_last), 32'd0);
            chk("idle_grant", 32'(grant_id), m_last);
            chk("idle_cnt", 32'(dbg_byte_cnt), m_cnt);
            if (cyc >= free_at && |src_valid) begin
               pend   = 1'b1;
               pend_g = rr_pick(m_last, src_valid);
            end
         end
         cyc++;
      end
   end

   task automatic step_drive();
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (q[i].size() == 0) begin
            src_valid[i] = 1'b0;
            src_last[i]  = 1'b0;
         end else begin
            if (!(src_valid[i] && !acc[i]))
               src_valid[i] = ($urandom_range(99) < vpct);
            src_data[8*i +: 8] = q[i][0].d;
            src_last[i]        = q[i][0].l;
         end
      end
      tx_ready = toggle_rdy ? ~tx_ready : ($urandom_range(99) < rpct);
   endtask

   task automatic run_until_done(int maxcyc, string name);
      int n = 0;
      while ((q_pending() || m_busy || pend) && n < maxcyc) begin
         step_drive();
         n++;
      end
      if (n >= maxcyc) chk({name, "_timeout"}, 32'd1, 32'd0);
      repeat (GAP_CYCLES + 3) step_drive();
   endtask

   task automatic do_reset();
      mon_en    = 1'b0;
      rst       = 1'b1;
      src_valid = '0;
      src_last  = '0;
      src_data  = '0;
      tx_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic add_pkt(int s, int len, logic [7:0] base);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.d = base + 8'(k);
         b.l = (k == len - 1);
         q[s].push_back(b);
      end
   endtask

   row_t tbl[10];

   initial begin
      tbl[0] = '{2'b01, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'd1, 1'b0, 16'd0};
      tbl[1] = '{2'b01, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 2'b01, 2'd0, 1'b1, 16'd0};
      tbl[2] = '{2'b01, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 2'b01, 2'd0, 1'b1, 16'd1};
      tbl[3] = '{2'b01, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 2'b01, 2'd0, 1'b1, 16'd2};
      tbl[4] = '{2'b01, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 2'b01, 2'd0, 1'b1, 16'd3};
      tbl[5] = '{2'b01, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'd0, 1'b0, 16'd4};
      tbl[6] = '{2'b01, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'd0, 1'b0, 16'd4};
      tbl[7] = '{2'b01, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'd0, 1'b0, 16'd4};
      tbl[8] = '{2'b01, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 2'b01, 2'd0, 1'b1, 16'd0};
      tbl[9] = '{2'b00, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'd0, 1'b0, 16'd1};

      // 4-byte packet, gap, then a single-byte packet
      do_reset();
      for (int r = 0; r < 10; r++) begin
         @(posedge clk);
         #1;
         src_valid     = tbl[r].v;
         src_data[7:0] = tbl[r].d0;
         src_last      = {1'b0, tbl[r].l0};
         tx_ready      = tbl[r].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_tv", r), 32'(tx_valid), 32'(tbl[r].tv));
         chk($sformatf("tbl%0d_td", r), 32'(tx_data), 32'(tbl[r].td));
         chk($sformatf("tbl%0d_dd", r), 32'(dbg_data), 32'(tbl[r].td));
         chk($sformatf("tbl%0d_tl", r), 32'(tx_last), 32'(tbl[r].tl));
         chk($sformatf("tbl%0d_sr", r), 32'(src_ready), 32'(tbl[r].sr));
         chk($sformatf("tbl%0d_gid", r), 32'(grant_id), 32'(tbl[r].gid));
         chk($sformatf("tbl%0d_busy", r), 32'(dbg_busy), 32'(tbl[r].busy));
         chk($sformatf("tbl%0d_cnt", r), 32'(dbg_byte_cnt), 32'(tbl[r].cnt));
      end

      // both sources always requesting: grants alternate
      do_reset();
      add_pkt(0, 2, 8'h10);
      add_pkt(0, 2, 8'h20);
      add_pkt(1, 2, 8'h30);
      add_pkt(1, 2, 8'h40);
      vpct = 100;
      rpct = 100;
      mon_en = 1'b1;
      run_until_done(200, "rr");
      chk("rr_count", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         chk($sformatf("rr_order%0d", i), grant_log[i], i % 2);

      // source 1 packet under a toggling tx_ready
      do_reset();
      add_pkt(1, 3, 8'hB1);
      toggle_rdy = 1'b1;
      mon_en = 1'b1;
      run_until_done(200, "stall");
      toggle_rdy = 1'b0;
      chk("stall_accepts", nacc, 32'd3);
      chk("stall_cnt", 32'(dbg_byte_cnt), 32'd3);
      chk("stall_grant", 32'(grant_id), 32'd1);

      // reset during byte 2 of a 5-byte packet
      do_reset();
      @(posedge clk);
      #1;
      src_valid     = 2'b01;
      src_data[7:0] = 8'h10;
      src_last      = 2'b00;
      tx_ready      = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 src_data[7:0] = 8'h20;
      #1;
      chk("mid_valid", 32'(tx_valid), 32'd1);
      chk("mid_data", 32'(tx_data), 32'h20);
      chk("mid_cnt", 32'(dbg_byte_cnt), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_ready", 32'(src_ready), 32'd0);
      chk("rst_busy", 32'(dbg_busy), 32'd0);
      chk("rst_grant", 32'(grant_id), NUM_SRC - 1);
      chk("rst_cnt", 32'(dbg_byte_cnt), 32'd0);
      src_valid = 2'b11;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_busy", 32'(dbg_busy), 32'd1);
      chk("post_rst_grant", 32'(grant_id), 32'd0);

      // randomized traffic
      do_reset();
      for (int s = 0; s < NUM_SRC; s++)
         for (int p = 0; p < 15; p++)
            add_pkt(s, $urandom_range(1, 8), 8'($urandom));
      vpct = 70;
      rpct = 70;
      mon_en = 1'b1;
      run_until_done(6000, "rand");
      chk("rand_pkts", npkt, 32'(NUM_SRC * 15));

      // long packet saturates the byte counter
      do_reset();
      add_pkt(0, 70000, 8'h00);
      vpct = 100;
      rpct = 100;
      mon_en = 1'b1;
      run_until_done(71000, "sat");
      chk("sat_cnt", 32'(dbg_byte_cnt), 32'hFFFF);
      chk("sat_pkts", npkt, 32'd1);
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single UDP transmit byte stream among NUM_SRC packet sources.
- Holds a grant from first byte to last byte of one packet, then inserts a programmable inter-packet gap.
- Exports debug signals (busy flag, current byte, byte count) sized 1/8/16 bits to suit the on-chip logic-analyser probe ports.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..4).
- GAP_CYCLES, 2, idle cycles forced between packets (1..15).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- src_valid  input  NUM_SRC  per-source byte valid; bit i = source i.
- src_data  input  8*NUM_SRC  per-source byte; source i at [8i+7:8i].
- src_last  input  NUM_SRC  per-source last byte of packet.
- src_ready  output  NUM_SRC  per-source accept.
- tx_valid  output  1  byte valid to UDP TX.
- tx_data  output  8  byte to UDP TX.
- tx_last  output  1  last byte of packet.
- tx_ready  input  1  UDP TX accept.
- grant_id  output  2  index of the current/last granted source.
- dbg_busy  output  1  high in XFER.
- dbg_data  output  8  copy of tx_data.
- dbg_byte_cnt  output  16  bytes accepted in the current/last packet.

Behaviour:
- Handshake: a byte transfers when valid and ready are both high on a clk edge. The source must hold valid/data/last until accepted.
- States: IDLE, XFER, GAP. Reset state is IDLE.
- IDLE:
  - Round-robin search starts at (grant_id+1) mod NUM_SRC and picks the first i with src_valid[i]=1.
  - If a source is found: latch grant_id=i, clear dbg_byte_cnt to 0, next state XFER.
  - If none is found: stay in IDLE.
  - Arbitration costs one cycle; the first byte can transfer at the earliest on the cycle after the request is seen.
- XFER (combinational pass-through, zero added latency):
  - tx_valid=src_valid[g], tx_data=src_data[g], tx_last=src_last[g], src_ready[g]=tx_ready, where g=grant_id.
  - All other src_ready bits are 0.
  - On each accepted byte: dbg_byte_cnt increments, saturating at 0xFFFF.
  - Accepted byte with tx_last=1: next state GAP, gap counter loaded with GAP_CYCLES-1.
  - A source deasserting valid mid-packet keeps the grant; the arbiter waits indefinitely.
- GAP:
  - tx_valid=0 and all src_ready=0.
  - Gap counter decrements each cycle; at 0, next state IDLE.
  - Total idle time on tx between the last byte and the next packet's first byte is GAP_CYCLES+1 cycles (gap plus arbitration).
- Outside XFER: tx_valid=0, tx_last=0, tx_data=0, src_ready=0.
- grant_id and dbg_byte_cnt retain their values outside XFER until the next grant.
- dbg_busy=(state==XFER). dbg_data=tx_data.
- Reset values:
  - state=IDLE; grant_id=NUM_SRC-1, so source 0 wins the first arbitration.
  - dbg_byte_cnt=0, gap counter=0.
  - All outputs 0, except grant_id=NUM_SRC-1.
- Reset mid-packet: state returns to IDLE immediately (asynchronous). The partial packet is truncated without tx_last; the downstream UDP TX handles the truncation.
- Simultaneous requests: exactly one winner per round-robin order. A request arriving during XFER or GAP is honoured only in the next IDLE.
- Single-byte packet (valid and last on the first byte) is legal: XFER lasts one accepted beat.
- tx_ready low: everything stalls. data/last must equal the source's held values; the count does not advance.

Test Plan:
- Reset, then src_valid=2'b01 with a 4-byte packet 0x11..0x44, tx_ready=1 -> grant_id=0, four bytes passed in order, tx_last on 0x44, dbg_byte_cnt=4, 3 idle cycles (GAP_CYCLES=2) before tx_valid can rise again.
- Both sources continuously requesting with 2-byte packets -> grant order 0,1,0,1; src_ready of the non-granted source stays 0.
- Grant source 1 and toggle tx_ready 1,0,1,0 during a 3-byte packet -> each byte held stable while stalled; exactly 3 accepts; dbg_byte_cnt=3.
- Single-byte packet 0xA5 with last=1 from source 0 -> one XFER beat, tx_data=0xA5, tx_last=1, then GAP.
- Assert rst in the middle of byte 2 of a 5-byte packet -> tx_valid=0 and src_ready=0 immediately; grant_id=NUM_SRC-1 and dbg_byte_cnt=0 after reset; the next request from source 0 wins.
- Send a 70000-byte packet -> dbg_byte_cnt saturates at 0xFFFF; the packet still completes on last.
